// File: rtl/mul_div_sequencer.sv
// Multi-cycle MULTU/DIVU/MTHI/MTLO sequencer that owns the architectural HI/LO registers.
// Latency: MULTU/DIVU commit HI/LO WIDTH edges after Start, Done follows; MTHI/MTLO and DIVU-by-zero commit at the Start edge.
// Backpressure: Busy is high while iterating; Start is ignored outside IDLE, with no queueing.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [5:0]       ALUFunction,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;      // multiplicand
    logic [WIDTH-1:0] p_hi, p_lo; // partial product; p_lo also shifts out the multiplier
    logic [WIDTH-1:0] r_reg;      // partial remainder
    logic [WIDTH-1:0] q_reg;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_reg;      // divisor
    logic [CW-1:0]    cnt;
    logic             dbz_flag;   // the pending DONE came from a divide by zero

    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] p_hi_nxt, p_lo_nxt;
    logic [WIDTH:0]   div_s, div_diff;
    logic [WIDTH-1:0] r_nxt, q_nxt;

    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign Busy      = (state == MUL) || (state == DIV);
    assign Done      = (state == DONE);
    assign DivByZero = (state == DONE) && dbz_flag;

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum  = p_lo[0] ? ({1'b0, p_hi} + {1'b0, a_reg}) : {1'b0, p_hi};
        p_hi_nxt = mul_sum[WIDTH:1];
        p_lo_nxt = {mul_sum[0], p_lo[WIDTH-1:1]};

        div_s    = {r_reg, q_reg[WIDTH-1]};
        div_diff = div_s - {1'b0, d_reg};
        if (!div_diff[WIDTH]) begin
            r_nxt = div_diff[WIDTH-1:0];
            q_nxt = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
            r_nxt = div_s[WIDTH-1:0];
            q_nxt = {q_reg[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; only IDLE looks at Start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start && ALUFunction == F_MULTU) begin
                    state_nxt = MUL;
                end else if (Start && ALUFunction == F_DIVU) begin
                    state_nxt = (RtData == '0) ? DONE : DIV;
                end
            end
            MUL:     if (last_iter) state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers, iteration counter and HI/LO; HI/LO only change at commit points.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            r_reg    <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            cnt      <= '0;
            dbz_flag <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (ALUFunction)
                            F_MULTU: begin
                                a_reg <= RsData;
                                p_hi  <= '0;
                                p_lo  <= RtData;
                                cnt   <= '0;
                            end
                            F_DIVU: begin
                                if (RtData == '0) begin
                                    HI       <= RsData;
                                    LO       <= '1;
                                    dbz_flag <= 1'b1;
                                end else begin
                                    r_reg <= '0;
                                    q_reg <= RsData;
                                    d_reg <= RtData;
                                    cnt   <= '0;
                                end
                            end
                            F_MTHI:  HI <= RsData;
                            F_MTLO:  LO <= RsData;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    p_hi <= p_hi_nxt;
                    p_lo <= p_lo_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        HI <= p_hi_nxt;
                        LO <= p_lo_nxt;
                    end
                end
                DIV: begin
                    r_reg <= r_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        HI <= r_nxt;
                        LO <= q_nxt;
                    end
                end
                DONE:    dbz_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomized bench for mul_div_sequencer against a plain-arithmetic HI/LO model.
// Inputs driven from the negative edge, outputs sampled on the negative edge.
// Every wait on Busy is bounded.
module tb_mul_div_sequencer;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [5:0]  ALUFunction = 6'b0;
    logic [31:0] RsData = '0;
    logic [31:0] RtData = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUFunction(ALUFunction),
        .RsData(RsData), .RtData(RtData), .Busy(Busy), .Done(Done),
        .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one instruction, follow it to completion and compare with the model.
    // inject: drive a stray MULTU Start in the middle of the busy window.
    task automatic do_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input bit inject);
        logic [63:0] prod;
        int          exp_nb, nb;
        bit          exp_done, exp_dbz, hold_ok;
        logic [31:0] old_hi, old_lo;
        old_hi   = m_hi;
        old_lo   = m_lo;
        exp_nb   = 0;
        exp_done = 0;
        exp_dbz  = 0;
        case (f)
            F_MULTU: begin
                prod = 64'(rs) * 64'(rt);
                m_hi = prod[63:32];
                m_lo = prod[31:0];
                exp_nb = 32; exp_done = 1;
            end
            F_DIVU: begin
                exp_done = 1;
                if (rt == 0) begin
                    m_hi = rs; m_lo = 32'hFFFF_FFFF; exp_dbz = 1;
                end else begin
                    m_hi = rs % rt; m_lo = rs / rt; exp_nb = 32;
                end
            end
            F_MTHI:  m_hi = rs;
            F_MTLO:  m_lo = rs;
            default: ;
        endcase

        @(negedge clk);
        Start = 1'b1; ALUFunction = f; RsData = rs; RtData = rt;
        @(posedge clk);
        #1 Start = 1'b0;
        ALUFunction = 6'b100001; RsData = $urandom; RtData = $urandom;

        nb = 0;
        hold_ok = 1;
        @(negedge clk);
        while (Busy && nb < 100) begin
            nb++;
            if (HI !== old_hi || LO !== old_lo || Done !== 1'b0) hold_ok = 0;
            if (inject && nb == 5) begin
                Start = 1'b1; ALUFunction = F_MULTU; RsData = $urandom; RtData = $urandom;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check("busy_cycles", 64'(nb), 64'(exp_nb));
        if (exp_nb > 0) check("hilo_held_while_busy", 64'(hold_ok), 64'd1);
        check("done", 64'(Done), 64'(exp_done));
        check("divbyzero", 64'(DivByZero), 64'(exp_dbz));
        check("hi", 64'(HI), 64'(m_hi));
        check("lo", 64'(LO), 64'(m_lo));
        if (exp_done) begin
            @(negedge clk);
            check("done_one_cycle", 64'(Done), 64'd0);
            check("dbz_one_cycle", 64'(DivByZero), 64'd0);
            check("idle_after_done", 64'(Busy), 64'd0);
        end
    endtask

    // Assert reset between clock edges and check the cleared state right away.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check({tag, "_hi"}, 64'(HI), 64'd0);
        check({tag, "_lo"}, 64'(LO), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_done"}, 64'(Done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_held_hi"}, 64'(HI), 64'd0);
        check({tag, "_held_busy"}, 64'(Busy), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] rs, rt;
        int          nb;

        // Power-on reset.
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        reset = 1'b0;

        // Directed corner cases.
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("max_mul_hi", 64'(HI), 64'hFFFF_FFFE);
        check("max_mul_lo", 64'(LO), 64'h0000_0001);
        do_op(F_DIVU, 32'd100, 32'd7, 0);
        check("div100_7_hi", 64'(HI), 64'd2);
        check("div100_7_lo", 64'(LO), 64'd14);
        do_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_big_hi", 64'(HI), 64'h8000_0000);
        check("div_big_lo", 64'(LO), 64'd0);
        do_op(F_DIVU, 32'h1234_5678, 32'd0, 0);

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        Start = 1'b1; ALUFunction = F_MTHI; RsData = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 ALUFunction = F_MTLO; RsData = 32'h5A5A_5A5A;
        @(negedge clk);
        check("mthi_hi", 64'(HI), 64'hA5A5_A5A5);
        check("mthi_no_done", 64'(Done), 64'd0);
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(LO), 64'h5A5A_5A5A);
        check("mtlo_hi_kept", 64'(HI), 64'hA5A5_A5A5);
        check("mtlo_no_done", 64'(Done), 64'd0);
        m_hi = 32'hA5A5_A5A5; m_lo = 32'h5A5A_5A5A;

        // Start during busy is ignored.
        do_op(F_MULTU, 32'd12345, 32'd678, 1);

        // Mid-cycle reset from idle with non-zero HI/LO.
        async_reset("arst_idle");

        // Reset aborts a multiply after 10 busy cycles, then the same multiply runs clean.
        @(negedge clk);
        Start = 1'b1; ALUFunction = F_MULTU; RsData = 32'd3; RtData = 32'd5;
        @(posedge clk);
        #1 Start = 1'b0;
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (Busy) nb++;
        end
        check("abort_busy_count", 64'(nb), 64'd10);
        async_reset("arst_busy");
        do_op(F_MULTU, 32'd3, 32'd5, 0);
        check("mul3x5_hi", 64'(HI), 64'd0);
        check("mul3x5_lo", 64'(LO), 64'd15);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    f = F_MULTU;
                2, 3:    f = F_DIVU;
                4:       f = ($urandom_range(0, 1) != 0) ? F_MTHI : F_MTLO;
                default: f = 6'($urandom_range(0, 63));
            endcase
            rs = $urandom;
            case ($urandom_range(0, 4))
                0:       rt = 32'd0;
                1:       rt = $urandom_range(1, 15);
                default: rt = $urandom;
            endcase
            do_op(f, rs, rt, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
